// File: rtl/zs_timer_pkg.sv
// Shared definitions for the zerosoc machine timer: TL-UL bus types,
// register offsets, reset constants and the response integrity helper.
package zs_timer_pkg;

    localparam logic [2:0] TL_PUT_FULL    = 3'h0;
    localparam logic [2:0] TL_PUT_PARTIAL = 3'h1;
    localparam logic [2:0] TL_GET         = 3'h4;
    localparam logic [2:0] TL_ACK         = 3'h0;
    localparam logic [2:0] TL_ACK_DATA    = 3'h1;

    localparam logic [4:0] TIMER_CTRL_OFFSET        = 5'h00;
    localparam logic [4:0] TIMER_PRESCALE_OFFSET    = 5'h04;
    localparam logic [4:0] TIMER_MTIME_LO_OFFSET    = 5'h08;
    localparam logic [4:0] TIMER_MTIME_HI_OFFSET    = 5'h0C;
    localparam logic [4:0] TIMER_MTIMECMP_LO_OFFSET = 5'h10;
    localparam logic [4:0] TIMER_MTIMECMP_HI_OFFSET = 5'h14;

    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic [3:0] instr_type;
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        tl_d_user_t  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    // Hsiao-style (39,32) check bits; each bit is the parity of a fixed data subset.
    function automatic logic [6:0] intg_ecc32(logic [31:0] d);
        logic [6:0] c;
        c[0] = ^(d & 32'h2606BD25);
        c[1] = ^(d & 32'hDEBA8050);
        c[2] = ^(d & 32'h413D89AA);
        c[3] = ^(d & 32'h31234ED1);
        c[4] = ^(d & 32'hC2C1323B);
        c[5] = ^(d & 32'h2DCC624C);
        c[6] = ^(d & 32'h98505586);
        return c;
    endfunction

endpackage

// File: rtl/zs_timer_rsp_intg.sv
// Fills d_user with response-header and data integrity on a TL-UL response.
module tlul_rsp_intg_gen
    import zs_timer_pkg::*;
(
    input  tl_d2h_t tl_i,
    output tl_d2h_t tl_o
);

    logic [31:0] rsp_hdr;
    logic        unused_user;

    assign rsp_hdr     = {tl_i.d_opcode, tl_i.d_size, tl_i.d_error, 26'b0};
    assign unused_user = ^tl_i.d_user;

    always_comb begin
        tl_o                  = tl_i;
        tl_o.d_user.rsp_intg  = intg_ecc32(rsp_hdr);
        tl_o.d_user.data_intg = intg_ecc32(tl_i.d_data);
    end

endmodule

// File: rtl/zs_timer.sv
// TL-UL machine timer: prescaled 64-bit mtime, 64-bit mtimecmp and a
// registered level interrupt; one outstanding transaction at a time.
module zs_timer
    import zs_timer_pkg::*;
#(
    parameter int PrescaleW = 12
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  tl_h2d_t tl_i,
    output tl_d2h_t tl_o,
    output logic    intr_timer_o
);

    logic                 enable_q, enable_d;
    logic [PrescaleW-1:0] prescale_q, prescale_d, pre_cnt_q, pre_cnt_d;
    logic [31:0]          mtime_lo_q, mtime_lo_d, mtime_hi_q, mtime_hi_d;
    logic [63:0]          mtimecmp_q, mtimecmp_d, mtime_inc;
    logic                 intr_q;

    logic        rsp_valid_q, rsp_error_q;
    logic [2:0]  rsp_opcode_q;
    logic [1:0]  rsp_size_q;
    logic [7:0]  rsp_source_q;
    logic [31:0] rsp_data_q;

    logic [4:0]  offset;
    logic        accept, is_get, is_put, mapped, req_err, wr_en, tick;
    logic [31:0] rdata;
    logic        unused_tl;

    assign offset    = tl_i.a_address[4:0];
    assign accept    = tl_i.a_valid & ~rsp_valid_q;
    assign is_get    = tl_i.a_opcode == TL_GET;
    assign is_put    = (tl_i.a_opcode == TL_PUT_FULL) | (tl_i.a_opcode == TL_PUT_PARTIAL);
    assign req_err   = ~mapped | (tl_i.a_size != 2'd2) | (is_put & (tl_i.a_mask != 4'hF))
                     | ~(is_get | is_put);
    assign wr_en     = accept & is_put & ~req_err;
    assign tick      = enable_q & (pre_cnt_q == prescale_q);
    assign mtime_inc = {mtime_hi_q, mtime_lo_q} + 64'd1;
    assign unused_tl = ^{tl_i.a_param, tl_i.a_address[31:5], tl_i.a_user};

    always_comb begin
        mapped = 1'b1;
        rdata  = 32'h0;
        case (offset)
            TIMER_CTRL_OFFSET:        rdata = {31'b0, enable_q};
            TIMER_PRESCALE_OFFSET:    rdata = 32'(prescale_q);
            TIMER_MTIME_LO_OFFSET:    rdata = mtime_lo_q;
            TIMER_MTIME_HI_OFFSET:    rdata = mtime_hi_q;
            TIMER_MTIMECMP_LO_OFFSET: rdata = mtimecmp_q[31:0];
            TIMER_MTIMECMP_HI_OFFSET: rdata = mtimecmp_q[63:32];
            default:                  mapped = 1'b0;
        endcase
    end

    always_comb begin
        enable_d   = enable_q;
        prescale_d = prescale_q;
        mtimecmp_d = mtimecmp_q;
        pre_cnt_d  = pre_cnt_q;
        if (enable_q) pre_cnt_d = tick ? '0 : pre_cnt_q + PrescaleW'(1);
        // A software write to one half wins over the tick; the written half
        // loses the increment and the carry into HI is dropped with it.
        mtime_lo_d = tick ? mtime_inc[31:0]  : mtime_lo_q;
        mtime_hi_d = tick ? mtime_inc[63:32] : mtime_hi_q;
        if (wr_en) begin
            case (offset)
                TIMER_CTRL_OFFSET:        enable_d = tl_i.a_data[0];
                TIMER_PRESCALE_OFFSET: begin
                    prescale_d = tl_i.a_data[PrescaleW-1:0];
                    pre_cnt_d  = '0;
                end
                TIMER_MTIME_LO_OFFSET: begin
                    mtime_lo_d = tl_i.a_data;
                    mtime_hi_d = mtime_hi_q;
                end
                TIMER_MTIME_HI_OFFSET:    mtime_hi_d = tl_i.a_data;
                TIMER_MTIMECMP_LO_OFFSET: mtimecmp_d[31:0]  = tl_i.a_data;
                TIMER_MTIMECMP_HI_OFFSET: mtimecmp_d[63:32] = tl_i.a_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            enable_q   <= 1'b0;
            prescale_q <= '0;
            pre_cnt_q  <= '0;
            mtime_lo_q <= '0;
            mtime_hi_q <= '0;
            mtimecmp_q <= MTIMECMP_RESET;
            intr_q     <= 1'b0;
        end else begin
            enable_q   <= enable_d;
            prescale_q <= prescale_d;
            pre_cnt_q  <= pre_cnt_d;
            mtime_lo_q <= mtime_lo_d;
            mtime_hi_q <= mtime_hi_d;
            mtimecmp_q <= mtimecmp_d;
            intr_q     <= {mtime_hi_q, mtime_lo_q} >= mtimecmp_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q  <= 1'b0;
            rsp_error_q  <= 1'b0;
            rsp_opcode_q <= TL_ACK;
            rsp_size_q   <= '0;
            rsp_source_q <= '0;
            rsp_data_q   <= '0;
        end else if (accept) begin
            rsp_valid_q  <= 1'b1;
            rsp_error_q  <= req_err;
            rsp_opcode_q <= is_get ? TL_ACK_DATA : TL_ACK;
            rsp_size_q   <= tl_i.a_size;
            rsp_source_q <= tl_i.a_source;
            rsp_data_q   <= (is_get & ~req_err) ? rdata : 32'h0;
        end else if (rsp_valid_q & tl_i.d_ready) begin
            rsp_valid_q  <= 1'b0;
        end
    end

    tl_d2h_t tl_rsp;

    always_comb begin
        tl_rsp          = '0;
        tl_rsp.d_valid  = rsp_valid_q;
        tl_rsp.d_opcode = rsp_opcode_q;
        tl_rsp.d_size   = rsp_size_q;
        tl_rsp.d_source = rsp_source_q;
        tl_rsp.d_data   = rsp_data_q;
        tl_rsp.d_error  = rsp_error_q;
        tl_rsp.a_ready  = ~rsp_valid_q;
    end

    tlul_rsp_intg_gen u_rsp_intg (
        .tl_i (tl_rsp),
        .tl_o (tl_o)
    );

    assign intr_timer_o = intr_q;

endmodule

// File: tb/tb_zs_timer.sv
// Directed bench for zs_timer: register access, prescaled counting, carry,
// interrupt timing, error responses, backpressure and async reset.
module tb_zs_timer;
    import zs_timer_pkg::*;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    tl_h2d_t tl_i;
    tl_d2h_t tl_o;
    logic    intr;
    int      errors = 0;
    int      checks = 0;

    always #5 clk = ~clk;

    zs_timer #(.PrescaleW(12)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .tl_i         (tl_i),
        .tl_o         (tl_o),
        .intr_timer_o (intr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tl_issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] mask, input logic [1:0] size, input logic [7:0] src);
        int n = 0;
        @(negedge clk);
        tl_i.a_opcode  = op;
        tl_i.a_address = addr;
        tl_i.a_data    = data;
        tl_i.a_mask    = mask;
        tl_i.a_size    = size;
        tl_i.a_source  = src;
        tl_i.a_valid   = 1'b1;
        while (!tl_o.a_ready && n < 10) begin @(negedge clk); n++; end
        if (n == 10) chk("a_ready_timeout", tl_o.a_ready, 1'b1);
        @(posedge clk);
        #1 tl_i.a_valid = 1'b0;
    endtask

    task automatic tl_complete(output logic [31:0] rdata, output logic err,
                               output logic [2:0] opc, output logic [7:0] src);
        int n = 0;
        while (!tl_o.d_valid && n < 10) begin @(negedge clk); n++; end
        chk("d_valid_seen", tl_o.d_valid, 1'b1);
        rdata = tl_o.d_data;
        err   = tl_o.d_error;
        opc   = tl_o.d_opcode;
        src   = tl_o.d_source;
        @(posedge clk);
        #1;
    endtask

    task automatic tl_rd(input logic [31:0] addr, input logic [1:0] size,
                         output logic [31:0] rdata, output logic err, output logic [2:0] opc);
        logic [7:0] src;
        tl_issue(TL_GET, addr, 32'h0, 4'hF, size, 8'h01);
        tl_complete(rdata, err, opc, src);
    endtask

    task automatic tl_wr(input logic [31:0] addr, input logic [31:0] data, input logic exp_err);
        logic [31:0] rd;
        logic        err;
        logic [2:0]  opc;
        logic [7:0]  src;
        tl_issue(TL_PUT_FULL, addr, data, 4'hF, 2'd2, 8'h02);
        tl_complete(rd, err, opc, src);
        chk("wr_err", err, exp_err);
        chk("wr_opcode", opc, TL_ACK);
    endtask

    logic [31:0] rd, lo1, lo2;
    logic        err;
    logic [2:0]  opc;
    logic [7:0]  src;
    logic [31:0] exp_rst [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tl_i = '0;
        tl_i.d_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_ready", tl_o.a_ready, 1'b1);
        chk("rst_d_valid", tl_o.d_valid, 1'b0);
        chk("rst_intr", intr, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            tl_rd(32'(i * 4), 2'd2, rd, err, opc);
            chk("rst_reg", rd, exp_rst[i]);
            chk("rst_err", err, 1'b0);
            chk("get_opcode", opc, TL_ACK_DATA);
        end
        chk("rst_intr_after_reads", intr, 1'b0);

        // PRESCALE=3 over 42 enabled cycles gives 10 ticks
        tl_wr(TIMER_PRESCALE_OFFSET, 32'd3, 1'b0);
        tl_wr(TIMER_CTRL_OFFSET, 32'd1, 1'b0);
        repeat (40) @(posedge clk);
        tl_wr(TIMER_CTRL_OFFSET, 32'd0, 1'b0);
        tl_rd(TIMER_MTIME_LO_OFFSET, 2'd2, lo1, err, opc);
        chk("presc_mtime_range", (lo1 >= 32'd9 && lo1 <= 32'd11), 1'b1);
        repeat (20) @(posedge clk);
        tl_rd(TIMER_MTIME_LO_OFFSET, 2'd2, lo2, err, opc);
        chk("presc_hold", lo2, lo1);

        // LO to HI carry: 0xFFFFFFFE plus 5 ticks
        tl_wr(TIMER_MTIME_LO_OFFSET, 32'hFFFF_FFFE, 1'b0);
        tl_wr(TIMER_MTIME_HI_OFFSET, 32'h0, 1'b0);
        tl_wr(TIMER_PRESCALE_OFFSET, 32'h0, 1'b0);
        tl_wr(TIMER_CTRL_OFFSET, 32'd1, 1'b0);
        repeat (3) @(posedge clk);
        tl_wr(TIMER_CTRL_OFFSET, 32'd0, 1'b0);
        tl_rd(TIMER_MTIME_HI_OFFSET, 2'd2, rd, err, opc);
        chk("carry_hi", rd, 32'd1);
        tl_rd(TIMER_MTIME_LO_OFFSET, 2'd2, rd, err, opc);
        chk("carry_lo_range", (rd >= 32'd2 && rd <= 32'd5), 1'b1);

        // Interrupt: mtime counts 1,2,3.. from enable; intr follows mtime==5 by one cycle
        tl_wr(TIMER_MTIME_HI_OFFSET, 32'h0, 1'b0);
        tl_wr(TIMER_MTIME_LO_OFFSET, 32'h0, 1'b0);
        tl_wr(TIMER_MTIMECMP_HI_OFFSET, 32'h0, 1'b0);
        tl_wr(TIMER_MTIMECMP_LO_OFFSET, 32'd5, 1'b0);
        chk("intr_before_enable", intr, 1'b0);
        tl_wr(TIMER_CTRL_OFFSET, 32'd1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("intr_rise_k%0d", k), intr, (k >= 6));
        end
        tl_issue(TL_PUT_FULL, TIMER_MTIMECMP_LO_OFFSET, 32'hFFFF_FFFF, 4'hF, 2'd2, 8'h03);
        chk("intr_held_1cyc", intr, 1'b1);
        tl_complete(rd, err, opc, src);
        chk("intr_dropped_2cyc", intr, 1'b0);
        tl_wr(TIMER_CTRL_OFFSET, 32'd0, 1'b0);

        // Error responses leave state untouched
        tl_rd(32'h18, 2'd2, rd, err, opc);
        chk("err_unmapped", err, 1'b1);
        chk("err_unmapped_data", rd, 32'h0);
        tl_rd(TIMER_CTRL_OFFSET, 2'd1, rd, err, opc);
        chk("err_size", err, 1'b1);
        tl_issue(TL_PUT_PARTIAL, TIMER_CTRL_OFFSET, 32'h1, 4'h3, 2'd2, 8'h04);
        tl_complete(rd, err, opc, src);
        chk("err_partial", err, 1'b1);
        chk("err_partial_opcode", opc, TL_ACK);
        tl_rd(TIMER_CTRL_OFFSET, 2'd2, rd, err, opc);
        chk("ctrl_unchanged", rd, 32'h0);
        chk("ctrl_rd_err", err, 1'b0);

        // Backpressure: response held stable while d_ready=0
        tl_i.d_ready = 1'b0;
        tl_issue(TL_GET, TIMER_MTIMECMP_LO_OFFSET, 32'h0, 4'hF, 2'd2, 8'h2A);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_d_valid", tl_o.d_valid, 1'b1);
            chk("bp_d_data", tl_o.d_data, 32'hFFFF_FFFF);
            chk("bp_d_source", tl_o.d_source, 8'h2A);
            chk("bp_a_ready", tl_o.a_ready, 1'b0);
        end
        tl_i.d_ready = 1'b1;
        @(negedge clk);
        chk("bp_d_valid_clr", tl_o.d_valid, 1'b0);
        chk("bp_a_ready_back", tl_o.a_ready, 1'b1);

        // Async reset drops a pending response and restores registers
        tl_wr(TIMER_PRESCALE_OFFSET, 32'd7, 1'b0);
        tl_i.d_ready = 1'b0;
        tl_issue(TL_GET, TIMER_PRESCALE_OFFSET, 32'h0, 4'hF, 2'd2, 8'h05);
        chk("pre_rst_d_valid", tl_o.d_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_d_valid", tl_o.d_valid, 1'b0);
        chk("arst_a_ready", tl_o.a_ready, 1'b1);
        tl_i.d_ready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        tl_rd(TIMER_PRESCALE_OFFSET, 2'd2, rd, err, opc);
        chk("arst_prescale", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
